// File: rtl/sr_mathunit.sv
// sr_mathunit: iterative unsigned coprocessor (MUL, DIVU, REMU, ISQRT) with a
// start/busy/done handshake. One iteration per clock in RUN.
// Build option: define SR_MATHUNIT_SQRT_EN to include the square-root datapath;
// without it op 3 completes immediately with err=1 and res=0.
module sr_mathunit #(
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] res,
  output logic           busy,
  output logic           done,
  output logic           err
);
`ifdef SR_MATHUNIT_SQRT_EN
  localparam int H = W / 2;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_DIVU  = 2'd1,
    OP_REMU  = 2'd2,
    OP_ISQRT = 2'd3
  } op_t;

  state_t           state;
  op_t              opR;
  logic [CNT_W-1:0] cnt;
  // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient};
  // ISQRT: {remainder, radicand}
  logic [2*W-1:0]   acc;
  logic [W-1:0]     opB;     // MUL multiplicand or divisor

  logic [2*W-1:0]   accNext;
  logic [2*W-1:0]   resNext;
  logic             lastIter;
  logic [W:0]       mulSum;
  logic [W:0]       divShift;
  logic             divGe;
  logic [W-1:0]     divDiff;
`ifdef SR_MATHUNIT_SQRT_EN
  logic [H-1:0]     root;
  logic [H-1:0]     rootNext;
  logic [H+2:0]     sqShift;
  logic             sqGe;
  logic [H+1:0]     sqDiff;
`endif

  // One iteration step of the selected operation and the result it would yield.
  always_comb begin
    mulSum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opB} : '0);
    divShift = acc[2*W-1:W-1];
    divGe    = divShift >= {1'b0, opB};
    // Only used when divShift >= opB, so the difference always fits in W bits.
    divDiff  = divShift[W-1:0] - opB;
    accNext  = acc;
    resNext  = '0;
    lastIter = (cnt == CNT_W'(W - 1));
`ifdef SR_MATHUNIT_SQRT_EN
    sqShift  = {acc[W+H:W], acc[W-1:W-2]};
    sqGe     = sqShift >= {1'b0, root, 2'b01};
    sqDiff   = sqShift[H+1:0] - {root, 2'b01};
    rootNext = root;
`endif
    case (opR)
      OP_MUL: begin
        accNext = {mulSum, acc[W-1:1]};
        resNext = accNext;
      end
      OP_DIVU, OP_REMU: begin
        if (divGe) accNext = {divDiff, acc[W-2:0], 1'b1};
        else       accNext = {acc[2*W-2:0], 1'b0};
        resNext = (opR == OP_DIVU) ? {{W{1'b0}}, accNext[W-1:0]}
                                   : {{W{1'b0}}, accNext[2*W-1:W]};
      end
      OP_ISQRT: begin
`ifdef SR_MATHUNIT_SQRT_EN
        lastIter           = (cnt == CNT_W'(H - 1));
        rootNext           = {root[H-2:0], sqGe};
        accNext            = '0;
        accNext[W+H+1:W]   = sqGe ? sqDiff : sqShift[H+1:0];
        accNext[W-1:0]     = {acc[W-3:0], 2'b00};
        resNext            = {{(2*W-H){1'b0}}, rootNext};
`endif
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opR   <= OP_MUL;
      cnt   <= '0;
      acc   <= '0;
      opB   <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef SR_MATHUNIT_SQRT_EN
      root  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opR <= op_t'(op);
            cnt <= '0;
`ifdef SR_MATHUNIT_SQRT_EN
            root <= '0;
`endif
            case (op_t'(op))
              OP_MUL: begin
                acc   <= {{W{1'b0}}, b};
                opB   <= a;
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_DIVU, OP_REMU: begin
                acc <= {{W{1'b0}}, a};
                opB <= b;
                if (b == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  res   <= (op_t'(op) == OP_DIVU) ? {{W{1'b0}}, {W{1'b1}}}
                                                  : {{W{1'b0}}, a};
                end else begin
                  busy  <= 1'b1;
                  state <= RUN;
                end
              end
              default: begin
`ifdef SR_MATHUNIT_SQRT_EN
                acc   <= {{W{1'b0}}, a};
                busy  <= 1'b1;
                state <= RUN;
`else
                state <= DONE;
                done  <= 1'b1;
                err   <= 1'b1;
                res   <= '0;
`endif
              end
            endcase
          end
        end
        RUN: begin
          acc <= accNext;
          cnt <= cnt + CNT_W'(1);
`ifdef SR_MATHUNIT_SQRT_EN
          root <= rootNext;
`endif
          if (lastIter) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b0;
            res   <= resNext;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_mathunit.sv
// tb_sr_mathunit: scoreboard bench for sr_mathunit (W=8). Stimulus pushes the
// expected result, error flag and completion cycle; a negedge monitor pops and
// compares whenever done is seen, and checks busy every cycle.
module tb_sr_mathunit;
  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             doneCyc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] res;
  logic           busy;
  logic           done;
  logic           err;

  int   cyc;
  int   checks;
  int   errors;
  bit   monEn;
  exp_t q[$];
  exp_t monE;

  sr_mathunit #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .res  (res),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands plus the latency rule.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int acceptCyc);
    exp_t r;
    longint unsigned ux, uy, s;
    int n;
    ux = x; uy = y; n = W; r.err = 1'b0; r.res = '0; s = 0;
    case (o)
      2'd0: r.res = (2*W)'(ux * uy);
      2'd1: if (uy == 0) begin r.res = (2*W)'((64'd1 << W) - 1); r.err = 1'b1; n = 0; end
            else r.res = (2*W)'(ux / uy);
      2'd2: if (uy == 0) begin r.res = (2*W)'(ux); r.err = 1'b1; n = 0; end
            else r.res = (2*W)'(ux % uy);
      default: begin
`ifdef SR_MATHUNIT_SQRT_EN
        while ((s + 1) * (s + 1) <= ux) s++;
        r.res = (2*W)'(s);
        n = W / 2;
`else
        r.res = '0; r.err = 1'b1; n = 0;
`endif
      end
    endcase
    r.doneCyc = acceptCyc + n;
    return r;
  endfunction

  // Monitor: busy expectation every cycle, result comparison on done.
  always @(negedge clk) begin
    if (monEn) begin
      if (q.size() != 0) chk("busy", busy, (cyc < q[0].doneCyc) ? 1 : 0);
      else               chk("busy_idle", busy, 0);
      if (done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          monE = q.pop_front();
          chk("res", res, monE.res);
          chk("err", err, monE.err);
          chk("done_cycle", cyc, monE.doneCyc);
        end
      end else if (q.size() != 0 && cyc > q[0].doneCyc) begin
        checks++; errors++;
        $display("FAIL missing_done actual=0 required=1 (cycle %0d)", cyc);
        void'(q.pop_front());
      end
    end
  end

  // Drive one request; the accept edge is the next posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    q.push_back(model(o, x, y, cyc));
  endtask

  // Wait (bounded) for done, then step into the following IDLE cycle.
  task automatic waitDone();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 64);
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks = 0; errors = 0; monEn = 1'b0;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res", res, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    monEn = 1'b1;
    @(negedge clk);

    issue(2'd0, 8'd255, 8'd255); waitDone();
    issue(2'd1, 8'd200, 8'd7);   waitDone();
    issue(2'd2, 8'd200, 8'd7);   waitDone();
    issue(2'd1, 8'd13,  8'd0);   waitDone();
    issue(2'd0, 8'd3,   8'd4);   waitDone();
    issue(2'd2, 8'd99,  8'd0);   waitDone();
    issue(2'd3, 8'd255, 8'd0);   waitDone();
    issue(2'd3, 8'd0,   8'd0);   waitDone();
    issue(2'd1, 8'd5,   8'd200); waitDone();

    // Starts during RUN (cycle 3) and DONE (cycle 9) must be ignored.
    issue(2'd0, 8'd10, 8'd10);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9);
      op = 2'd1; a = 8'd13; b = 8'd0;
    end
    @(negedge clk);
    issue(2'd1, 8'd13, 8'd0); waitDone();

    // Reset asserted in cycle 4 of a multiply aborts it.
    issue(2'd0, 8'd77, 8'd91);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    chk("midreset_busy", busy, 0);
    chk("midreset_res", res, 0);
    chk("midreset_done", done, 0);
    chk("midreset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'd0, 8'd255, 8'd255); waitDone();

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      issue(ro, ra, rb);
      waitDone();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
